// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared busy/start multiplier; MULT_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: grant, issue, wait_hi, multiplier busy time, resp; one IDLE cycle separates back-to-back operations.
// Backpressure: requests are only seen in IDLE while the multiplier is idle; requests at other times are dropped.
module mult_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] m0,
  input  logic [WIDTH-1:0] n0,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] n1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] prod_out,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_m,
  output logic [WIDTH-1:0] mult_n,
  input  logic [WIDTH-1:0] mult_prod,
  input  logic             mult_busy,
  output logic             arb_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   pick1;
  logic   grant;

`ifdef MULT_ARB_RR_EN
  logic last_srv;

  // On a tie the requester not served last wins.
  always_comb pick1 = req1 && (!req0 || (last_srv == 1'b0));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_srv <= 1'b1;
    end else if (grant) begin
      last_srv <= pick1;
    end
  end
`else
  always_comb pick1 = req1 && !req0;
`endif

  // A multiplier still running a result from before reset must drain before the next grant.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if ((req0 || req1) && !mult_busy && !reset) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT_HI;
      WAIT_HI: if (mult_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!mult_busy) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      mult_m   <= '0;
      mult_n   <= '0;
      prod_out <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner  <= pick1;
        mult_m <= pick1 ? m1 : m0;
        mult_n <= pick1 ? n1 : n0;
      end
      if ((state == WAIT_LO) && !mult_busy) begin
        prod_out <= mult_prod;
      end
    end
  end

  always_comb begin
    gnt0       = grant && !pick1;
    gnt1       = grant && pick1;
    mult_start = (state == ISSUE);
    done0      = (state == RESP) && !owner;
    done1      = (state == RESP) && owner;
    arb_busy   = (state != IDLE);
  end

endmodule
